// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES GF(2^8) helpers for the column mixing datapath.
//   AES_POLY   : reduction constant for x^8+x^4+x^3+x+1
//   byte_t     : one state byte
//   column_t   : one 32-bit state column, [31:24] = row 0
//   xtime()    : multiply a byte by {02} in GF(2^8)
//   rotl*()    : column byte rotations, byte i of result = byte i+k of input
//   state_e    : sequencing states of inv_mix_column_seq
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] column_t;

    // IDLE: waiting for a column. D1/D2: doubling steps.
    // HOLD: first cycle computes the result (out_valid still low), then the
    // result is held until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        D1   = 2'd1,
        D2   = 2'd2,
        HOLD = 2'd3
    } state_e;

    function automatic byte_t xtime(input byte_t b, input byte_t poly);
        return {b[6:0], 1'b0} ^ (b[7] ? poly : 8'h00);
    endfunction

    // Row i of a column sits at bits [31-8i -: 8], so rotating left by one
    // byte moves row i+1 into row i.
    function automatic column_t rotl8(input column_t c);
        return {c[23:0], c[31:24]};
    endfunction

    function automatic column_t rotl16(input column_t c);
        return {c[15:0], c[31:16]};
    endfunction

    function automatic column_t rotl24(input column_t c);
        return {c[7:0], c[31:8]};
    endfunction

endpackage

// File: rtl/gf_xtime4.sv
// ---------------------------------------------------------------------------
// gf_xtime4
// Four parallel GF(2^8) xtime lanes over a 32-bit column.
//   din  : input column (four bytes)
//   dout : each byte of din multiplied by {02}, reduced with POLY
// Purely combinational.
// ---------------------------------------------------------------------------
module gf_xtime4
    import aes_pkg::*;
#(
    parameter logic [7:0] POLY = AES_POLY
) (
    input  logic [31:0] din,
    output logic [31:0] dout
);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign dout[8*i +: 8] = xtime(din[8*i +: 8], POLY);
    end

endmodule

// File: rtl/inv_mix_column_seq.sv
// ---------------------------------------------------------------------------
// inv_mix_column_seq
// Sequential AES InvMixColumns on one 32-bit column. The multiples a2, a4
// are built by registered xtime doublings, a8 is formed combinationally in
// the final cycle, and the result is registered 3 edges after accept.
//   clock     : system clock, rising edge
//   resetn    : asynchronous active-low reset
//   in_valid  : in_col carries a column
//   in_ready  : block is idle and accepts a column
//   in_col    : column, [31:24] = row 0 ... [7:0] = row 3
//   out_valid : out_col holds a result
//   out_ready : consumer takes out_col
//   out_col   : result, same byte order as in_col
// Optional: define AES_FWD_MIX_EN to add input fwd, captured at accept;
// fwd=1 applies the forward MixColumns combine instead.
// ---------------------------------------------------------------------------
module inv_mix_column_seq
    import aes_pkg::*;
#(
    parameter logic [7:0] POLY = AES_POLY
) (
    input  logic        clock,
    input  logic        resetn,
`ifdef AES_FWD_MIX_EN
    input  logic        fwd,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_col,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_col
);

    state_e  state_q, state_d;
    column_t a_q, a_d;
    column_t a2_q, a2_d;
    column_t a4_q, a4_d;
    column_t out_col_q, out_col_d;
    logic    out_valid_q, out_valid_d;

`ifdef AES_FWD_MIX_EN
    logic    mode_q, mode_d;
`endif

    column_t a2_x, a4_x, a8_x;
    column_t m9, m11, m13, m14;
    column_t inv_col;
    column_t result;

    // Doubling lanes: a->2a and 2a->4a feed registers, 4a->8a feeds the
    // combine directly.
    gf_xtime4 #(.POLY(POLY)) u_x2 (.din(a_q),  .dout(a2_x));
    gf_xtime4 #(.POLY(POLY)) u_x4 (.din(a2_q), .dout(a4_x));
    gf_xtime4 #(.POLY(POLY)) u_x8 (.din(a4_q), .dout(a8_x));

    // Column-wide multiples, then row i gathers rows i..i+3 by rotation:
    // b_i = 14a_i ^ 11a_{i+1} ^ 13a_{i+2} ^ 9a_{i+3}
    assign m9  = a8_x ^ a_q;
    assign m11 = a8_x ^ a2_q ^ a_q;
    assign m13 = a8_x ^ a4_q ^ a_q;
    assign m14 = a8_x ^ a4_q ^ a2_q;
    assign inv_col = m14 ^ rotl8(m11) ^ rotl16(m13) ^ rotl24(m9);

`ifdef AES_FWD_MIX_EN
    column_t fwd_col;
    // b_i = 2a_i ^ 3a_{i+1} ^ a_{i+2} ^ a_{i+3}, with 2a already in a2_q
    assign fwd_col = a2_q ^ rotl8(a2_q ^ a_q) ^ rotl16(a_q) ^ rotl24(a_q);
    assign result  = mode_q ? fwd_col : inv_col;
`else
    assign result  = inv_col;
`endif

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        a2_d        = a2_q;
        a4_d        = a4_q;
        out_col_d   = out_col_q;
        out_valid_d = out_valid_q;
`ifdef AES_FWD_MIX_EN
        mode_d      = mode_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_col;
`ifdef AES_FWD_MIX_EN
                    mode_d  = fwd;
`endif
                    state_d = D1;
                end
            end
            D1: begin
                a2_d    = a2_x;
                state_d = D2;
            end
            D2: begin
                a4_d    = a4_x;
                state_d = HOLD;
            end
            HOLD: begin
                // Entry cycle has out_valid low: that is the compute cycle.
                if (!out_valid_q) begin
                    out_col_d   = result;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            a_q         <= '0;
            a2_q        <= '0;
            a4_q        <= '0;
            out_col_q   <= '0;
            out_valid_q <= 1'b0;
`ifdef AES_FWD_MIX_EN
            mode_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            a2_q        <= a2_d;
            a4_q        <= a4_d;
            out_col_q   <= out_col_d;
            out_valid_q <= out_valid_d;
`ifdef AES_FWD_MIX_EN
            mode_q      <= mode_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_col   = out_col_q;

endmodule

// File: tb/tb_inv_mix_column_seq.sv
// ---------------------------------------------------------------------------
// tb_inv_mix_column_seq
// Self-checking bench for inv_mix_column_seq. Expected columns come from
// known AES vectors or from a shift-and-add GF(2^8) multiply model, and are
// queued on drive and popped when the DUT presents a result.
// ---------------------------------------------------------------------------
module tb_inv_mix_column_seq;

    logic        clock = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_col;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_col;
`ifdef AES_FWD_MIX_EN
    logic        fwd;
`endif

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    inv_mix_column_seq dut (
        .clock    (clock),
        .resetn   (resetn),
`ifdef AES_FWD_MIX_EN
        .fwd      (fwd),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_col   (in_col),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_col  (out_col)
    );

    always #5 clock = ~clock;

    // Generic GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p = 8'h00;
        logic [7:0] a = x;
        logic [7:0] b = y;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] mix_model(input logic [31:0] c, input logic [7:0] k0,
                                              input logic [7:0] k1, input logic [7:0] k2,
                                              input logic [7:0] k3);
        logic [7:0]  s [4];
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) s[i] = c[31-8*i -: 8];
        for (int i = 0; i < 4; i++)
            r[31-8*i -: 8] = gmul(s[i], k0) ^ gmul(s[(i+1)%4], k1) ^
                             gmul(s[(i+2)%4], k2) ^ gmul(s[(i+3)%4], k3);
        return r;
    endfunction

    function automatic logic [31:0] inv_model(input logic [31:0] c);
        return mix_model(c, 8'd14, 8'd11, 8'd13, 8'd9);
    endfunction

    task automatic test_reset();
        resetn = 1'b0; in_valid = 1'b0; in_col = '0; out_ready = 1'b0;
`ifdef AES_FWD_MIX_EN
        fwd = 1'b0;
`endif
        repeat (2) @(negedge clock);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_col !== 32'h0) begin
            fails++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_col=%h, want 1 0 00000000",
                     in_ready, out_valid, out_col);
        end
        resetn = 1'b1;
        @(negedge clock);
    endtask

    // Per column: latency of 3 edges, in_ready low for 4 samples, value, release.
    task automatic test_vectors();
        logic [31:0] vc [6];
        logic [31:0] ve [6];
        logic [31:0] e;
        int lat, low;
        vc[0] = 32'h8E4DA1BC; ve[0] = 32'hDB135345;
        vc[1] = 32'h9FDC589D; ve[1] = 32'hF20A225C;
        vc[2] = 32'h01010101; ve[2] = 32'h01010101;
        vc[3] = 32'hC6C6C6C6; ve[3] = 32'hC6C6C6C6;
        vc[4] = $urandom();   ve[4] = inv_model(vc[4]);
        vc[5] = $urandom();   ve[5] = inv_model(vc[5]);
        out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            in_valid = 1'b1; in_col = vc[v];
            exp_q.push_back(ve[v]);
            @(negedge clock);
            in_valid = 1'b0;
            lat = 0; low = 0;
            while (!out_valid && lat < 20) begin
                if (!in_ready) low++;
                @(negedge clock);
                lat++;
            end
            if (!in_ready) low++;
            tests++;
            if (lat !== 3) begin
                fails++;
                $display("FAIL vec%0d latency: got %0d edges, want 3", v, lat);
            end
            tests++;
            if (low !== 4) begin
                fails++;
                $display("FAIL vec%0d in_ready low: got %0d cycles, want 4", v, low);
            end
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL vec%0d scoreboard empty, got %h", v, out_col);
            end else begin
                e = exp_q.pop_front();
                if (out_col !== e) begin
                    fails++;
                    $display("FAIL vec%0d out_col: got %h, want %h", v, out_col, e);
                end
            end
            @(negedge clock);
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL vec%0d release: out_valid=%b in_ready=%b, want 0 1",
                         v, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e;
        int n;
        int bad;
        out_ready = 1'b0;
        in_valid = 1'b1; in_col = 32'h9FDC589D;
        exp_q.push_back(32'hF20A225C);
        @(negedge clock);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clock); n++; end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; in_col = 32'h12345678;
            tests++;
            if (out_valid !== 1'b1 || out_col !== e || in_ready !== 1'b0) begin
                fails++; bad++;
                $display("FAIL stall c%0d: out_valid=%b out_col=%h in_ready=%b, want 1 %h 0",
                         c, out_valid, out_col, in_ready, e);
            end
            @(negedge clock);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_col !== e) begin
            fails++;
            $display("FAIL stall release: out_valid=%b in_ready=%b out_col=%h, want 0 1 %h",
                     out_valid, in_ready, out_col, e);
        end
        // A column offered during the stall must not have been taken.
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid || !in_ready) n++;
            @(negedge clock);
        end
        tests++;
        if (n !== 0) begin
            fails++;
            $display("FAIL stall ignored input: busy for %0d cycles, want 0", n);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] e;
        int n;
        out_ready = 1'b1;
        in_valid = 1'b1; in_col = 32'h8E4DA1BC;
        @(negedge clock);          // D1
        in_valid = 1'b0;
        @(negedge clock);          // D2
        resetn = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_col !== 32'h0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL midreset: out_valid=%b out_col=%h in_ready=%b, want 0 00000000 1",
                     out_valid, out_col, in_ready);
        end
        @(negedge clock);
        resetn = 1'b1;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) n++;
            @(negedge clock);
        end
        tests++;
        if (n !== 0) begin
            fails++;
            $display("FAIL midreset partial output: out_valid high %0d cycles, want 0", n);
        end
        in_valid = 1'b1; in_col = 32'hC6C6C6C6;
        exp_q.push_back(32'hC6C6C6C6);
        @(negedge clock);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clock); n++; end
        tests++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        if (out_valid !== 1'b1 || out_col !== e) begin
            fails++;
            $display("FAIL midreset recovery: out_valid=%b out_col=%h, want 1 %h",
                     out_valid, out_col, e);
        end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        logic [31:0] cols [3];
        logic [31:0] e;
        int sent, got, last, cyc;
        logic rdy_prev;
        for (int i = 0; i < 3; i++) cols[i] = $urandom();
        out_ready = 1'b1;
        in_valid = 1'b1; in_col = cols[0];
        exp_q.push_back(inv_model(cols[0]));
        sent = 1; got = 0; last = 0; cyc = 0;
        rdy_prev = in_ready;
        while (got < 3 && cyc < 60) begin
            @(negedge clock);
            cyc++;
            if (rdy_prev && in_valid) begin
                if (sent < 3) begin
                    in_col = cols[sent];
                    exp_q.push_back(inv_model(cols[sent]));
                    sent++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                tests++;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
                if (out_col !== e) begin
                    fails++;
                    $display("FAIL b2b r%0d out_col: got %h, want %h", got, out_col, e);
                end
                if (got > 0) begin
                    tests++;
                    if (cyc - last !== 5) begin
                        fails++;
                        $display("FAIL b2b r%0d spacing: got %0d cycles, want 5", got, cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
            rdy_prev = in_ready;
        end
        in_valid = 1'b0;
        tests++;
        if (got !== 3 || exp_q.size() !== 0) begin
            fails++;
            $display("FAIL b2b count: got %0d results with %0d left queued, want 3 and 0",
                     got, exp_q.size());
        end
        @(negedge clock);
    endtask

`ifdef AES_FWD_MIX_EN
    task automatic test_fwd();
        logic [31:0] e;
        int n;
        out_ready = 1'b1;
        for (int m = 1; m >= 0; m--) begin
            fwd = m[0];
            in_valid = 1'b1; in_col = 32'hDB135345;
            exp_q.push_back(m == 1 ? 32'h8E4DA1BC : inv_model(32'hDB135345));
            @(negedge clock);
            in_valid = 1'b0; fwd = ~fwd;   // mode must come from the captured value
            n = 0;
            while (!out_valid && n < 20) begin @(negedge clock); n++; end
            tests++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
            if (out_valid !== 1'b1 || n !== 3 || out_col !== e) begin
                fails++;
                $display("FAIL fwd=%0d: out_valid=%b lat=%0d out_col=%h, want 1 3 %h",
                         m, out_valid, n, out_col, e);
            end
            @(negedge clock);
        end
        fwd = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef AES_FWD_MIX_EN
        test_fwd();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
